// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared FSM state type and default geometry for the
// single-port RAM arbiter. Optional feature macro: RAM_PORT_ARBITER_LOCK_EN.
package ram_port_arbiter_pkg;

    // Default configuration
    localparam int DEF_NREQ   = 4;
    localparam int DEF_AW     = 6;
    localparam int DEF_DW     = 18;
    localparam int DEF_RD_LAT = 1;

    // Read-latency counter width (RD_LAT is at most 3)
    localparam int CNT_W = 2;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: combinational round-robin pick. Searches the request vector
// starting at index ptr and wrapping at NREQ; returns the first hit.
module ram_arb_rr #(
    parameter int NREQ = 4,
    parameter int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic [GW-1:0]   gnt,
    output logic            any
);

    logic [GW-1:0] gnt_s;
    logic          any_s;
    int            idx_s;

    // Rotating priority search from ptr upward, first requester found wins
    always_comb begin
        gnt_s = '0;
        any_s = 1'b0;
        idx_s = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx_s = int'(ptr) + i;
            if (idx_s >= NREQ) begin
                idx_s = idx_s - NREQ;
            end else begin
                idx_s = idx_s;
            end
            if (!any_s && req[idx_s]) begin
                any_s = 1'b1;
                gnt_s = GW'(idx_s);
            end else begin
                any_s = any_s;
            end
        end
    end

    assign gnt = gnt_s;
    assign any = any_s;

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM among NREQ requesters with
// round-robin arbitration and at most one transaction outstanding.
// Writes occupy 2 cycles (IDLE pick, ISSUE); reads add RD_LAT RDWAIT cycles.
// Optional feature macro: RAM_PORT_ARBITER_LOCK_EN adds req_lock, letting the
// current grantee keep priority for the next arbitration.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic                CLK,
    input  logic                ALn,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ-1:0]     req_we,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*DW-1:0]  req_wdata,
`ifdef RAM_PORT_ARBITER_LOCK_EN
    input  logic [NREQ-1:0]     req_lock,
`endif
    output logic [NREQ-1:0]     rsp_valid,
    output logic [DW-1:0]       rsp_rdata,
    output logic                ram_en,
    output logic                ram_we,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_wdata,
    input  logic [DW-1:0]       ram_rdata
);

    localparam int GW = $clog2(NREQ);

    arb_state_e     state_r, state_nxt_s;
    logic [GW-1:0]  ptr_r, ptr_nxt_s;
    logic [GW-1:0]  gnt_r, gnt_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;

    logic [GW-1:0]   rr_gnt_s;
    logic            rr_any_s;
    logic [GW-1:0]   ptr_inc_s;
    logic            lock_s;
    logic            issue_s;
    logic            rsp_s;
    logic [NREQ-1:0] gnt_oh_s;

    ram_arb_rr #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_rr (
        .req (req_valid),
        .ptr (ptr_r),
        .gnt (rr_gnt_s),
        .any (rr_any_s)
    );

`ifdef RAM_PORT_ARBITER_LOCK_EN
    assign lock_s = req_lock[gnt_r];
`else
    assign lock_s = 1'b0;
`endif

    assign ptr_inc_s = (gnt_r == GW'(NREQ - 1)) ? GW'(0) : (gnt_r + GW'(1));
    assign gnt_oh_s  = {{(NREQ-1){1'b0}}, 1'b1} << gnt_r;

    // State, pointer, grant and latency counter registers
    always_ff @(posedge CLK or negedge ALn) begin
        if (!ALn) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            gnt_r   <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            gnt_r   <= gnt_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic: grant is frozen from the pick until the return to IDLE
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        gnt_nxt_s   = gnt_r;
        cnt_nxt_s   = cnt_r;
        issue_s     = 1'b0;
        rsp_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (rr_any_s) begin
                    gnt_nxt_s   = rr_gnt_s;
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (req_valid[gnt_r]) begin
                    issue_s   = 1'b1;
                    ptr_nxt_s = lock_s ? gnt_r : ptr_inc_s;
                    if (req_we[gnt_r]) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = RDWAIT;
                        cnt_nxt_s   = CNT_W'(RD_LAT);
                    end
                end else begin
                    // Requester withdrew: nothing issued, pointer left alone
                    state_nxt_s = IDLE;
                end
            end
            RDWAIT: begin
                cnt_nxt_s = cnt_r - CNT_W'(1);
                // <= also recovers from a corrupted zero count
                if (cnt_r <= CNT_W'(1)) begin
                    rsp_s       = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RDWAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Output decode: everything is forced to zero outside its active cycle
    always_comb begin
        req_ready = '0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        rsp_valid = '0;
        rsp_rdata = '0;
        if (issue_s) begin
            req_ready = gnt_oh_s;
            ram_en    = 1'b1;
            ram_we    = req_we[gnt_r];
            ram_addr  = req_addr[gnt_r*AW +: AW];
            ram_wdata = req_wdata[gnt_r*DW +: DW];
        end else begin
            req_ready = '0;
        end
        if (rsp_s) begin
            rsp_valid = gnt_oh_s;
            rsp_rdata = ram_rdata;
        end else begin
            rsp_valid = '0;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench with a transaction scoreboard.
// Main instance uses RD_LAT=1; a second instance with RD_LAT=3 covers
// reset during a read wait. Lock checks build when RAM_PORT_ARBITER_LOCK_EN
// is defined.
module tb_ram_port_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 6;
    localparam int DW   = 18;

    typedef struct {
        int            idx;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } rsp_t;

    logic                CLK;
    logic                ALn;
    logic                ALn3;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_valid3;
    logic [NREQ-1:0]     req_we;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_wdata;
    logic [NREQ-1:0]     req_lock;

    logic [NREQ-1:0]     req_ready,  req_ready3;
    logic [NREQ-1:0]     rsp_valid,  rsp_valid3;
    logic [DW-1:0]       rsp_rdata,  rsp_rdata3;
    logic                ram_en,     ram_en3;
    logic                ram_we,     ram_we3;
    logic [AW-1:0]       ram_addr,   ram_addr3;
    logic [DW-1:0]       ram_wdata,  ram_wdata3;
    logic [DW-1:0]       ram_rdata,  ram_rdata3;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_iss    = -1;
    bit gap_chk     = 1'b0;

    txn_t txn_q[$];
    rsp_t rsp_q[$];
    txn_t mon_t;
    rsp_t mon_r;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_q;

    ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(1)) dut (
        .CLK       (CLK),
        .ALn       (ALn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef RAM_PORT_ARBITER_LOCK_EN
        .req_lock  (req_lock),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
        .CLK       (CLK),
        .ALn       (ALn3),
        .req_valid (req_valid3),
        .req_ready (req_ready3),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef RAM_PORT_ARBITER_LOCK_EN
        .req_lock  (req_lock),
`endif
        .rsp_valid (rsp_valid3),
        .rsp_rdata (rsp_rdata3),
        .ram_en    (ram_en3),
        .ram_we    (ram_we3),
        .ram_addr  (ram_addr3),
        .ram_wdata (ram_wdata3),
        .ram_rdata (ram_rdata3)
    );

    assign ram_rdata3 = 18'h15555;
    assign ram_rdata  = rd_q;

    initial begin
        CLK = 1'b0;
    end
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural RAM with one cycle read latency for the main instance
    always @(posedge CLK) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) rd_q <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_we[i]          = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic push_txn(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.idx = i; t.we = we; t.addr = a; t.data = d;
        txn_q.push_back(t);
    endtask

    task automatic push_rsp(input int i, input logic [DW-1:0] d);
        rsp_t r;
        r.idx = i; r.data = d;
        rsp_q.push_back(r);
    endtask

    // Scoreboard monitor on the main instance, sampled on the falling edge
    always @(negedge CLK) begin
        if (ram_en === 1'b1) begin
            if (txn_q.size() == 0) begin
                chk("issue_unexpected", 64'(ram_en), 64'd0);
            end else begin
                mon_t = txn_q.pop_front();
                chk("issue_grant", 64'(req_ready), 64'(4'b0001 << mon_t.idx));
                chk("issue_we",    64'(ram_we),    64'(mon_t.we));
                chk("issue_addr",  64'(ram_addr),  64'(mon_t.addr));
                chk("issue_wdata", 64'(ram_wdata), 64'(mon_t.data));
            end
            if (gap_chk && last_iss >= 0) chk("issue_gap", 64'(cyc - last_iss), 64'd2);
            last_iss = cyc;
        end else begin
            chk("idle_zero", 64'({ram_we, req_ready, ram_addr, ram_wdata}), 64'd0);
        end
        if (rsp_valid !== 4'b0000) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                mon_r = rsp_q.pop_front();
                chk("rsp_idx",  64'(rsp_valid), 64'(4'b0001 << mon_r.idx));
                chk("rsp_data", 64'(rsp_rdata), 64'(mon_r.data));
            end
        end else begin
            chk("rsp_rdata_idle", 64'(rsp_rdata), 64'd0);
        end
    end

    initial begin
        ALn        = 1'b0;
        ALn3       = 1'b0;
        req_valid  = '0;
        req_valid3 = '0;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_lock   = '0;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ram_en", 64'(ram_en), 64'd0);
        chk("rst_ready",  64'(req_ready), 64'd0);
        chk("rst_rsp",    64'(rsp_valid), 64'd0);
        cyc_step();
        ALn = 1'b1;
        cyc_step();

        // Single write from requester 0
        set_req(0, 1'b1, 6'h05, 18'h2ABCD);
        push_txn(0, 1'b1, 6'h05, 18'h2ABCD);
        req_valid = 4'b0001;
        @(negedge CLK);
        chk("wr_ready_early", 64'(req_ready), 64'd0);
        cyc_step();
        @(negedge CLK);
        chk("wr_ready", 64'(req_ready), 64'(4'b0001));
        chk("wr_ram_we", 64'(ram_we), 64'd1);
        cyc_step();
        req_valid = 4'b0000;
        @(negedge CLK);
        chk("wr_en_done", 64'(ram_en), 64'd0);
        chk("wr_no_rsp", 64'(rsp_valid), 64'd0);
        cyc_step();

        // Read-back of the same address
        set_req(0, 1'b0, 6'h05, 18'h00000);
        push_txn(0, 1'b0, 6'h05, 18'h00000);
        push_rsp(0, 18'h2ABCD);
        req_valid = 4'b0001;
        @(negedge CLK);
        chk("rd_rsp_early0", 64'(rsp_valid), 64'd0);
        cyc_step();
        @(negedge CLK);
        chk("rd_ready", 64'(req_ready), 64'(4'b0001));
        chk("rd_rsp_early1", 64'(rsp_valid), 64'd0);
        cyc_step();
        req_valid = 4'b0000;
        @(negedge CLK);
        chk("rd_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
        chk("rd_rsp_data", 64'(rsp_rdata), 64'(18'h2ABCD));
        cyc_step();
        @(negedge CLK);
        chk("rd_rsp_pulse", 64'(rsp_valid), 64'd0);
        cyc_step();

        // Asynchronous reset while requester 3 is in ISSUE (pointer is 1 here)
        set_req(3, 1'b1, 6'h3F, 18'h3FFFF);
        push_txn(3, 1'b1, 6'h3F, 18'h3FFFF);
        req_valid = 4'b1000;
        cyc_step();
        @(negedge CLK);
        chk("rst_iss_ready", 64'(req_ready), 64'(4'b1000));
        #1;
        ALn = 1'b0;
        #1;
        chk("rst_async_out", 64'({ram_en, ram_we, req_ready, ram_addr, ram_wdata}), 64'd0);
        req_valid = 4'b0000;
        repeat (2) cyc_step();
        ALn = 1'b1;
        cyc_step();

        // Fairness: all four write continuously, grants 0,1,2,3,0 two cycles apart
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'b1, 6'(6'h10 + i), 18'(32'h01100 * (i + 1)));
        end
        push_txn(0, 1'b1, 6'h10, 18'h01100);
        push_txn(1, 1'b1, 6'h11, 18'h02200);
        push_txn(2, 1'b1, 6'h12, 18'h03300);
        push_txn(3, 1'b1, 6'h13, 18'h04400);
        push_txn(0, 1'b1, 6'h10, 18'h01100);
        last_iss  = -1;
        gap_chk   = 1'b1;
        req_valid = 4'b1111;
        repeat (10) cyc_step();
        req_valid = 4'b0000;
        gap_chk   = 1'b0;
        chk("fair_all_issued", 64'(txn_q.size()), 64'd0);
        cyc_step();

        // Dropped request: requester 2 valid for a single cycle (pointer is 1)
        set_req(2, 1'b1, 6'h22, 18'h12345);
        req_valid = 4'b0100;
        cyc_step();
        req_valid = 4'b0000;
        @(negedge CLK);
        chk("drop_no_en", 64'(ram_en), 64'd0);
        chk("drop_no_ready", 64'(req_ready), 64'd0);
        cyc_step();
        push_txn(1, 1'b1, 6'h11, 18'h02200);
        req_valid = 4'b1111;
        @(negedge CLK);
        chk("drop_idle", 64'(ram_en), 64'd0);
        cyc_step();
        @(negedge CLK);
        chk("drop_ptr_kept", 64'(req_ready), 64'(4'b0010));
        cyc_step();
        req_valid = 4'b0000;
        cyc_step();

`ifdef RAM_PORT_ARBITER_LOCK_EN
        // Lock: requester 1 holds priority, then releases to requester 2
        ALn = 1'b0;
        cyc_step();
        ALn = 1'b1;
        cyc_step();
        set_req(1, 1'b1, 6'h31, 18'h0AAAA);
        set_req(2, 1'b1, 6'h32, 18'h05555);
        push_txn(1, 1'b1, 6'h31, 18'h0AAAA);
        push_txn(1, 1'b1, 6'h31, 18'h0AAAA);
        push_txn(1, 1'b1, 6'h31, 18'h0AAAA);
        push_txn(2, 1'b1, 6'h32, 18'h05555);
        req_lock  = 4'b0010;
        req_valid = 4'b0110;
        repeat (4) cyc_step();
        req_lock = 4'b0000;
        repeat (4) cyc_step();
        req_valid = 4'b0000;
        chk("lock_all_issued", 64'(txn_q.size()), 64'd0);
        cyc_step();
`endif

        // Reset during RDWAIT on the RD_LAT=3 instance
        ALn3 = 1'b1;
        cyc_step();
        set_req(0, 1'b0, 6'h05, 18'h00000);
        req_valid3 = 4'b0001;
        cyc_step();
        @(negedge CLK);
        chk("r3_issue", 64'(ram_en3), 64'd1);
        cyc_step();
        req_valid3 = 4'b0000;
        cyc_step();
        @(negedge CLK);
        chk("r3_wait_no_rsp", 64'(rsp_valid3), 64'd0);
        #1;
        ALn3 = 1'b0;
        #1;
        chk("r3_async_out", 64'({req_ready3, rsp_valid3, ram_en3, ram_we3, ram_addr3, ram_wdata3}), 64'd0);
        chk("r3_async_rdata", 64'(rsp_rdata3), 64'd0);
        repeat (2) cyc_step();
        ALn3 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            chk("r3_no_rsp_after_rst", 64'(rsp_valid3), 64'd0);
            cyc_step();
        end

        chk("txn_q_empty", 64'(txn_q.size()), 64'd0);
        chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
